asic_ioctrl: RTL and testbench



---
 rtl/asic_ioctrl.sv | 169 ++++++++++++++++
 tb/tb_asic_ioctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_ioctrl.sv
// asic_ioctrl: padring config shift-chain sequencer with power-up isolation.
// Define IOCTRL_PARITY_EN to append an even-parity bit after each pad word.
module asic_ioctrl #(
  parameter int NCTRL = 8,
  parameter int NPADS = 8,
  parameter int CFGW = 8,
  parameter int CLKDIV = 2,
  parameter int POR_CYCLES = 16,
  parameter logic [CFGW-1:0] CFGRST = '0
) (
  input  logic clk,
  input  logic nreset,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [$clog2(NPADS)-1:0] cfg_addr,
  input  logic [CFGW-1:0] cfg_data,
  input  logic cfg_commit,
  output logic busy,
  output logic done,
  output logic io_ready,
  output logic [NCTRL-1:0] ctrlring
);

`ifdef IOCTRL_PARITY_EN
  localparam int WW = CFGW + 1;
`else
  localparam int WW = CFGW;
`endif
  localparam int NBITS = NPADS * WW;
  localparam int BW = $clog2(NBITS);
  localparam int PW = $clog2(2 * CLKDIV);
  localparam int CMAX0 = (POR_CYCLES > CLKDIV) ? POR_CYCLES : CLKDIV;
  localparam int CMAX = (CMAX0 > 2) ? CMAX0 : 2;
  localparam int CW = $clog2(CMAX);

  typedef enum logic [1:0] {
    POR_WAIT,
    SHIFT,
    LOAD,
    IDLE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bitc, bitc_n;
  logic [BW-1:0] bidx;
  logic [PW-1:0] ph, ph_n;
  logic pend, pend_n;
  logic done_n;
  logic acc;
  logic in_range;
  logic [31:0] addr_ext;
  logic [CFGW-1:0] shadow [NPADS];
  logic [NBITS-1:0] img;
  logic sclk, sdata, load;

  assign cfg_ready = (state == IDLE) && !pend;
  assign acc = cfg_valid && cfg_ready;
  assign addr_ext = 32'(cfg_addr);
  assign in_range = addr_ext < NPADS;
  assign busy = (state != IDLE) || pend;

  // Pad p occupies img[p*WW +: WW]; the stream walks img from the MSB down
  always_comb begin
    img = '0;
    for (int p = 0; p < NPADS; p++) begin
`ifdef IOCTRL_PARITY_EN
      img[p*WW +: WW] = {shadow[p], ^shadow[p]};
`else
      img[p*WW +: WW] = shadow[p];
`endif
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int p = 0; p < NPADS; p++) begin
        shadow[p] <= CFGRST;
      end
    end else if (acc && in_range) begin
      shadow[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bitc_n = bitc;
    ph_n = ph;
    pend_n = pend;
    done_n = 1'b0;
    unique case (state)
      POR_WAIT: begin
        if (cnt == CW'(POR_CYCLES - 1)) begin
          cnt_n = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (ph == PW'(2 * CLKDIV - 1)) begin
          ph_n = '0;
          if (bitc == BW'(NBITS - 1)) begin
            bitc_n = '0;
            state_n = LOAD;
          end else begin
            bitc_n = bitc + BW'(1);
          end
        end else begin
          ph_n = ph + PW'(1);
        end
      end
      LOAD: begin
        if (cnt == CW'(CLKDIV - 1)) begin
          cnt_n = '0;
          done_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      IDLE: begin
        // One registered cycle lets the committed word land in the shadow
        if (pend) begin
          pend_n = 1'b0;
          state_n = SHIFT;
        end else if (acc && cfg_commit) begin
          pend_n = 1'b1;
        end
      end
      default: state_n = POR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= POR_WAIT;
      cnt <= '0;
      bitc <= '0;
      ph <= '0;
      pend <= 1'b0;
      done <= 1'b0;
      io_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitc <= bitc_n;
      ph <= ph_n;
      pend <= pend_n;
      done <= done_n;
      io_ready <= io_ready || done_n;
    end
  end

  assign bidx = BW'(NBITS - 1) - bitc;
  assign sclk = (state == SHIFT) && (ph >= PW'(CLKDIV));
  assign sdata = (state == SHIFT) && img[bidx];
  assign load = (state == LOAD);

  always_comb begin
    ctrlring = '0;
    ctrlring[0] = sclk;
    ctrlring[1] = sdata;
    ctrlring[2] = load;
    ctrlring[3] = !io_ready;
  end

endmodule

// File: tb/tb_asic_ioctrl.sv
// tb_asic_ioctrl: scoreboard bench for asic_ioctrl.
// Instance 0 uses defaults; instance 1 is a short chain with out-of-range addresses.
module tb_asic_ioctrl;

`ifdef IOCTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB0 = 8 * (8 + PAR);
  localparam int NB1 = 5 * (4 + PAR);
  localparam int INIT0 = 16 + 2 * 2 * NB0 + 2;
  localparam int COMMIT0 = 2 * 2 * NB0 + 2 + 1;
  localparam int INIT1 = 4 + 2 * 1 * NB1 + 1;
  localparam int COMMIT1 = 2 * 1 * NB1 + 1 + 1;
  localparam logic [3:0] RST1 = 4'h9;

  logic clk;
  logic nreset;
  logic cv [2];
  logic cc [2];
  logic [2:0] ca [2];
  logic [7:0] cd [2];
  logic rdy [2];
  logic dn [2];
  logic bsy [2];
  logic iordy [2];
  logic [7:0] ring [2];

  bit q0 [$];
  bit q1 [$];
  logic [7:0] sh0 [8];
  logic [3:0] sh1 [5];
  int popped [2];
  logic prev_s [2];
  logic prev_l [2];
  int hcnt [2];
  int lcnt [2];
  int nerr;
  int nchk;

  asic_ioctrl u_dut0 (
    .clk(clk),
    .nreset(nreset),
    .cfg_valid(cv[0]),
    .cfg_ready(rdy[0]),
    .cfg_addr(ca[0]),
    .cfg_data(cd[0]),
    .cfg_commit(cc[0]),
    .busy(bsy[0]),
    .done(dn[0]),
    .io_ready(iordy[0]),
    .ctrlring(ring[0])
  );

  asic_ioctrl #(
    .NCTRL(8),
    .NPADS(5),
    .CFGW(4),
    .CLKDIV(1),
    .POR_CYCLES(4),
    .CFGRST(RST1)
  ) u_dut1 (
    .clk(clk),
    .nreset(nreset),
    .cfg_valid(cv[1]),
    .cfg_ready(rdy[1]),
    .cfg_addr(ca[1]),
    .cfg_data(cd[1][3:0]),
    .cfg_commit(cc[1]),
    .busy(bsy[1]),
    .done(dn[1]),
    .io_ready(iordy[1]),
    .ctrlring(ring[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_models();
    for (int p = 0; p < 8; p++) sh0[p] = 8'h00;
    for (int p = 0; p < 5; p++) sh1[p] = RST1;
  endtask

  task automatic push_image(input int d);
    if (d == 0) begin
      for (int p = 7; p >= 0; p--) begin
        for (int b = 7; b >= 0; b--) q0.push_back(sh0[p][b]);
`ifdef IOCTRL_PARITY_EN
        q0.push_back(^sh0[p]);
`endif
      end
    end else begin
      for (int p = 4; p >= 0; p--) begin
        for (int b = 3; b >= 0; b--) q1.push_back(sh1[p][b]);
`ifdef IOCTRL_PARITY_EN
        q1.push_back(^sh1[p]);
`endif
      end
    end
  endtask

  task automatic mon_step(input int d);
    logic s, sd, l;
    bit e;
    int sz, cdv;
    s = ring[d][0];
    sd = ring[d][1];
    l = ring[d][2];
    cdv = (d == 0) ? 2 : 1;
    if (!nreset) begin
      prev_s[d] = 1'b0;
      prev_l[d] = 1'b0;
      hcnt[d] = 0;
      lcnt[d] = 0;
      return;
    end
    if (s && !prev_s[d]) begin
      sz = (d == 0) ? q0.size() : q1.size();
      check("stream_expected", sz > 0, 1);
      if (sz > 0) begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check((d == 0) ? "sdata0" : "sdata1", sd, e);
        popped[d]++;
      end
    end
    if (s) hcnt[d]++;
    if (!s && prev_s[d]) begin
      check("sclk_high", hcnt[d], cdv);
      hcnt[d] = 0;
    end
    if (l) begin
      lcnt[d]++;
      check("load_lines", {s, sd}, 0);
    end
    if (!l && prev_l[d]) begin
      check("load_len", lcnt[d], cdv);
      lcnt[d] = 0;
    end
    prev_s[d] = s;
    prev_l[d] = l;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  task automatic wr(input int d, input int addr, input logic [7:0] data,
                    input logic commit);
    @(negedge clk);
    cv[d] = 1'b1;
    ca[d] = 3'(addr);
    cd[d] = data;
    cc[d] = commit;
    check("cfg_ready", rdy[d], 1);
    @(posedge clk);
    #1;
    cv[d] = 1'b0;
    cc[d] = 1'b0;
    if (d == 0 && addr < 8) sh0[addr] = data;
    if (d == 1 && addr < 5) sh1[addr] = data[3:0];
    if (commit) push_image(d);
  endtask

  task automatic wait_done(input int d, input int lat);
    int n;
    bit rdy_bad, iso_bad;
    n = 0;
    rdy_bad = 0;
    iso_bad = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (dn[d]) break;
      if (rdy[d]) rdy_bad = 1;
      if (ring[d][3]) iso_bad = 1;
    end
    check("done_lat", n, lat);
    check("ready_low_busy", rdy_bad, 0);
    check("iso_stays_low", iso_bad, 0);
    check("idle_busy", bsy[d], 0);
    check("idle_ready", rdy[d], 1);
    check("io_ready_kept", iordy[d], 1);
  endtask

  task automatic wait_init();
    int n0, n1;
    n0 = -1;
    n1 = -1;
    for (int n = 1; n <= 1000 && (n0 < 0 || n1 < 0); n++) begin
      @(posedge clk);
      #1;
      if (n == 1) check("por_busy", bsy[0], 1);
      if (n0 < 0 && iordy[0]) begin
        n0 = n;
        check("init_done0", dn[0], 1);
        check("init_iso0", ring[0][3], 0);
        check("init_busy0", bsy[0], 0);
      end
      if (n1 < 0 && iordy[1]) begin
        n1 = n;
        check("init_done1", dn[1], 1);
        check("init_iso1", ring[1][3], 0);
      end
    end
    check("init_lat0", n0, INIT0);
    check("init_lat1", n1, INIT1);
  endtask

  task automatic check_reset_vals();
    check("rst_ring0", ring[0], 8'h08);
    check("rst_busy0", bsy[0], 1);
    check("rst_ready0", rdy[0], 0);
    check("rst_done0", dn[0], 0);
    check("rst_ioready0", iordy[0], 0);
    check("rst_ring1", ring[1], 8'h08);
  endtask

  initial begin
    int base;
    nerr = 0;
    nchk = 0;
    nreset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0;
      cc[d] = 1'b0;
      ca[d] = '0;
      cd[d] = '0;
      popped[d] = 0;
    end
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    #1;
    nreset = 1'b1;
    push_image(0);
    push_image(1);
    wait_init();
    check("init_q0_empty", q0.size(), 0);
    check("init_q1_empty", q1.size(), 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", dn[0], 0);

    wr(0, 7, 8'hA5, 1'b0);
    wr(0, 0, 8'h3C, 1'b1);
    wait_done(0, COMMIT0);
    check("commit_q0_empty", q0.size(), 0);

    // Request held through a whole sequence must wait for IDLE
    wr(0, 2, 8'h11, 1'b1);
    cv[0] = 1'b1;
    ca[0] = 3'd3;
    cd[0] = 8'h77;
    cc[0] = 1'b0;
    wait_done(0, COMMIT0);
    @(posedge clk);
    #1;
    cv[0] = 1'b0;
    sh0[3] = 8'h77;
    check("held_q0_empty", q0.size(), 0);
    check("after_write_ready", rdy[0], 1);
    wr(0, 4, 8'hC3, 1'b1);
    wait_done(0, COMMIT0);

    wr(1, 2, 8'h05, 1'b0);
    wr(1, 6, 8'h0F, 1'b0);
    wr(1, 7, 8'h0E, 1'b1);
    wait_done(1, COMMIT1);
    check("oor_q1_empty", q1.size(), 0);

    wr(0, 1, 8'h81, 1'b1);
    base = popped[0];
    for (int n = 0; n < 2000 && popped[0] < base + 20; n++) @(posedge clk);
    check("bits_before_rst", popped[0] - base, 20);
    #2;
    nreset = 1'b0;
    #1;
    check_reset_vals();
    q0.delete();
    q1.delete();
    reset_models();
    repeat (3) @(posedge clk);
    #2;
    nreset = 1'b1;
    push_image(0);
    push_image(1);
    wait_init();
    check("reinit_q0_empty", q0.size(), 0);
    check("reinit_q1_empty", q1.size(), 0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
